// File: rtl/sort_seq_ctrl.sv
// rtl/sort_seq_ctrl.sv - bubble-sort sequencer sharing one sort2 compare-and-swap unit
//
// Loads N words, sorts them ascending with one adjacent compare-swap per clock,
// then streams them out smallest first.
// Optional feature macro: SORT_EARLY_EXIT_EN (leave SORT after a pass with no swaps).
//
// Ports:
//   clk, reset_n                    clock (rising edge), async active-low reset
//   in_valid, in_data, in_ready     word input stream
//   out_valid, out_data, out_ready  sorted word output stream
//   busy                            high while sorting
//   sort_done                       one-cycle pulse on the first OUT cycle
//   swap_cnt                        swaps in the last/current sort, saturating

module sort2 #(
    parameter int W = 4
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic         swapped
);
    // Strict compare: equal words stay in place and are not counted.
    assign swapped = (in0 > in1);
    assign out0    = swapped ? in1 : in0;
    assign out1    = swapped ? in0 : in1;
endmodule

module sort_seq_ctrl #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          sort_done,
    output logic [CW-1:0] swap_cnt
);
    localparam int PW = (N > 2) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_PTR  = PW'(N - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(N - 2);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   mem_q [N];
    logic [W-1:0]   mem_d [N];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  pass_q, pass_d;
    logic [PW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  swap_cnt_q, swap_cnt_d;
    logic           sort_done_q, sort_done_d;
`ifdef SORT_EARLY_EXIT_EN
    logic           pass_swapped_q, pass_swapped_d;
`endif

    logic [PW-1:0]  idx_nx;
    logic [W-1:0]   s_out0, s_out1;
    logic           s_swap;
    logic           pass_end;

    assign idx_nx = idx_q + 1'b1;
    // Pass p compares positions 0..N-2-p; the tail above that is already final.
    assign pass_end = (idx_q == (LAST_PASS - pass_q));

    sort2 #(.W(W)) u_sort2 (
        .in0     (mem_q[idx_q]),
        .in1     (mem_q[idx_nx]),
        .out0    (s_out0),
        .out1    (s_out1),
        .swapped (s_swap)
    );

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pass_d      = pass_q;
        idx_d       = idx_q;
        swap_cnt_d  = swap_cnt_q;
        sort_done_d = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        pass_swapped_d = pass_swapped_q;
`endif
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_ptr_q] = in_data;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d   = '0;
                        pass_d     = '0;
                        idx_d      = '0;
                        swap_cnt_d = '0;
                        state_d    = ST_SORT;
`ifdef SORT_EARLY_EXIT_EN
                        pass_swapped_d = 1'b0;
`endif
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_SORT: begin
                mem_d[idx_q]  = s_out0;
                mem_d[idx_nx] = s_out1;
                if (s_swap && (swap_cnt_q != {CW{1'b1}})) begin
                    swap_cnt_d = swap_cnt_q + 1'b1;
                end
                if (pass_end) begin
                    idx_d  = '0;
                    pass_d = pass_q + 1'b1;
                    if (pass_q == LAST_PASS) begin
                        state_d     = ST_OUT;
                        sort_done_d = 1'b1;
                    end
`ifdef SORT_EARLY_EXIT_EN
                    // A clean pass means the whole frame is already in order.
                    else if (!(pass_swapped_q || s_swap)) begin
                        state_d     = ST_OUT;
                        sort_done_d = 1'b1;
                    end
                    pass_swapped_d = 1'b0;
`endif
                end else begin
                    idx_d = idx_nx;
`ifdef SORT_EARLY_EXIT_EN
                    pass_swapped_d = pass_swapped_q | s_swap;
`endif
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        rd_ptr_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pass_q      <= '0;
            idx_q       <= '0;
            swap_cnt_q  <= '0;
            sort_done_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
`ifdef SORT_EARLY_EXIT_EN
            pass_swapped_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pass_q      <= pass_d;
            idx_q       <= idx_d;
            swap_cnt_q  <= swap_cnt_d;
            sort_done_q <= sort_done_d;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef SORT_EARLY_EXIT_EN
            pass_swapped_q <= pass_swapped_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q == ST_SORT);
    assign sort_done = sort_done_q;
    assign swap_cnt  = swap_cnt_q;
    assign out_data  = (state_q == ST_OUT) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb/tb_sort_seq_ctrl.sv - randomized self-checking bench for sort_seq_ctrl
module tb_sort_seq_ctrl;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 8;

    typedef logic [W-1:0] word_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          busy;
    logic          sort_done;
    logic [CW-1:0] swap_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sort_seq_ctrl #(.N(N), .W(W), .CW(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .sort_done (sort_done),
        .swap_cnt  (swap_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bubble sort swaps exactly once per inverted pair.
    function automatic int model_swaps(input word_t d[N]);
        int c = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (d[i] > d[j]) c++;
        return c;
    endfunction

    // Each pass moves every element with larger words ahead of it one step left,
    // so the number of swapping passes is the largest such left-inversion count.
    function automatic int model_latency(input word_t d[N]);
        int lat = 0;
`ifdef SORT_EARLY_EXIT_EN
        int k = 0;
        int passes;
        for (int i = 0; i < N; i++) begin
            int c = 0;
            for (int j = 0; j < i; j++)
                if (d[j] > d[i]) c++;
            if (c > k) k = c;
        end
        passes = (k + 1 < N - 1) ? k + 1 : N - 1;
        for (int p = 0; p < passes; p++) lat += N - 1 - p;
`else
        lat = N * (N - 1) / 2;
`endif
        return lat;
    endfunction

    task automatic load_words(input word_t d[N], output bit ok);
        int bound;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            bound = 0;
            forever begin
                @(negedge clk);
                in_data  = d[i];
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid && in_ready) break;
                bound++;
                if (bound > 50) begin
                    check("load_timeout", 0, 1);
                    in_valid = 1'b0;
                    ok = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // rmode: 0 = out_ready always high, 1 = random, 2 = held low 5 OUT cycles first
    task automatic run_frame(input word_t d[N], input int rmode);
        word_t q[$];
        int busy_n = 0;
        int done_n = 0;
        int bound;
        int stall = 0;
        bit acc;
        bit ok;
        for (int i = 0; i < N; i++) q.push_back(d[i]);
        q.sort();

        load_words(d, ok);
        if (!ok) return;

        bound = 0;
        while (!out_valid && bound < 200) begin
            if (busy) busy_n++;
            if (sort_done) done_n++;
            if (in_ready) check("in_ready_sort", in_ready, 0);
            @(negedge clk);
            bound++;
        end
        check("sort_timeout", out_valid, 1);
        if (!out_valid) return;

        for (int k = 0; k < N; k++) begin
            bound = 0;
            forever begin
                if (sort_done) done_n++;
                check("out_valid", out_valid, 1);
                check("in_ready_out", in_ready, 0);
                check("out_data", out_data, q[k]);
                if (rmode == 0) out_ready = 1'b1;
                else if (rmode == 1) out_ready = ($urandom_range(0, 1) != 0);
                else begin
                    out_ready = (stall >= 5);
                    stall++;
                end
                acc = out_ready;
                @(negedge clk);
                if (acc) break;
                bound++;
                if (bound > 50) begin
                    check("out_timeout", 0, 1);
                    out_ready = 1'b0;
                    return;
                end
            end
        end
        out_ready = 1'b0;
        check("end_out_valid", out_valid, 0);
        check("end_in_ready", in_ready, 1);
        check("end_sort_done", sort_done, 0);
        check("swap_cnt", swap_cnt, model_swaps(d));
        check("sort_done_pulses", done_n, 1);
        check("busy_cycles", busy_n, model_latency(d));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sort_done"}, sort_done, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_swap_cnt"}, swap_cnt, 0);
    endtask

    initial begin
        word_t d[N];
        bit ok;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        d = '{4'd15, 4'd0, 4'd7, 4'd3};  run_frame(d, 0);
        d = '{4'd15, 4'd14, 4'd13, 4'd12}; run_frame(d, 0);
        d = '{4'd1, 4'd2, 4'd3, 4'd4};   run_frame(d, 0);
        d = '{4'd5, 4'd5, 4'd9, 4'd5};   run_frame(d, 1);
        d = '{4'd8, 4'd1, 4'd6, 4'd2};   run_frame(d, 2);

        // Reset on the second SORT cycle discards the frame.
        d = '{4'd9, 4'd4, 4'd3, 4'd2};
        load_words(d, ok);
        check("pre_reset_busy", busy, 1);
        @(negedge clk);
        check("pre_reset_busy2", busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midsort_rst");
        @(negedge clk);
        reset_n = 1'b1;
        d = '{4'd2, 4'd0, 4'd1, 4'd3};   run_frame(d, 0);

        for (int f = 0; f < 30; f++) begin
            int hi = (f % 3 == 0) ? 2 : 15;
            for (int i = 0; i < N; i++) d[i] = word_t'($urandom_range(0, hi));
            run_frame(d, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sort_seq_ctrl.md
Name: sort_seq_ctrl

Overview:
- Sequencer that time-shares one sort2 compare-and-swap unit to sort N words in ascending order.
- Flow per frame:
  - Accepts N words over a valid/ready input stream.
  - Runs a bubble sort, one adjacent compare-swap per clock, through an internal sort2 instance.
  - Streams the sorted words out over a valid/ready output.
- Sits between a data source and a consumer in the lab3 sorting datapath.

Parameters:
- N, 4, number of words per frame (N >= 2).
- W, 4, word width in bits (matches sort2 port width).
- CW, 8, width of swap counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a word.
- in_data  input  W  word to load.
- in_ready  output  1  block accepts a word this cycle.
- out_valid  output  1  out_data holds a sorted word.
- out_data  output  W  sorted word, smallest first.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  high in SORT state.
- sort_done  output  1  one-cycle pulse on the SORT->OUT transition.
- swap_cnt  output  CW  swaps performed in the last or current sort; saturates at all-ones.

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, reset_n. All state updates on the rising edge of clk.
- Reset (asynchronous, any state, including mid-SORT or mid-OUT):
  - state=LOAD; wr_ptr, rd_ptr, pass, idx, swap_cnt, all storage words = 0.
  - in_ready=1; out_valid=0; busy=0; sort_done=0; out_data=0.
  - A partial frame is discarded.
- Storage: mem[0..N-1], each W bits.
- sort2 convention: out0=min(in0,in1), out1=max(in0,in1); equal values are not swapped.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: mem[wr_ptr]<=in_data, wr_ptr++.
  - On acceptance of word N-1: go to SORT; clear wr_ptr, pass, idx, swap_cnt.
- SORT (busy=1, in_ready=0, out_valid=0):
  - Each cycle, sort2 gets in0=mem[idx], in1=mem[idx+1]; writes mem[idx]<=out0, mem[idx+1]<=out1.
  - If mem[idx] > mem[idx+1] (strict), swap_cnt++ (saturating).
  - idx runs 0..N-2-pass. At the end of a pass: idx=0, pass++.
  - After pass N-2 completes, go to OUT.
  - Sort latency without the optional feature: exactly N(N-1)/2 cycles (6 for N=4). Triangular bubble, fixed count.
- sort_done=1 for exactly the one cycle in which state first reads OUT.
- OUT:
  - out_valid=1; out_data=mem[rd_ptr]; in_ready=0.
  - On out_valid&&out_ready: rd_ptr++.
  - After word N-1 is accepted: rd_ptr=0, go to LOAD.
  - out_data is held stable while out_ready=0.
- swap_cnt holds its value through OUT and LOAD until the next SORT entry clears it.
- Data is bitwise-preserved: the output multiset equals the input multiset.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined:
  - A per-pass flag records whether any swap occurred.
  - If a pass completes with zero swaps, go to OUT immediately after that pass; latency = cycles actually executed.
  - An already-sorted frame takes N-1 cycles.
- Undefined:
  - Flag logic absent; SORT always takes N(N-1)/2 cycles.
- Output data, swap_cnt and the handshakes are identical in both builds.

Test Plan:
- Load 15,0,7,3; out_ready=1 -> out 0,3,7,15; swap_cnt=4; busy high 6 cycles; sort_done single pulse.
- Load 15,14,13,12 -> out 12,13,14,15; swap_cnt=6; busy 6 cycles in both builds.
- Load 1,2,3,4 -> out 1,2,3,4; swap_cnt=0; busy 3 cycles with SORT_EARLY_EXIT_EN, 6 without.
- Load 5,5,9,5 -> out 5,5,5,9; swap_cnt=1; equal values never counted.
- Load 8,1,6,2 with out_ready held low 5 cycles in OUT -> out_data stays 1, out_valid stays 1; then out 1,2,6,8; in_ready=0 throughout OUT.
- Load 9,4,3,2, assert reset_n=0 on the 2nd SORT cycle -> outputs immediately at reset values. Then load 2,0,1,3 -> out 0,1,2,3; swap_cnt=2.
